// File: rtl/look_ahead_window_fifo.sv
// look_ahead_window_fifo: FIFO exposing its WINDOW oldest entries with variable per-cycle retire.
module look_ahead_window_fifo #(
  parameter int DW = 16,
  parameter int DEPTH = 16,
  parameter int WINDOW = 4,
  parameter int AF_LEVEL = 12,
  parameter int AW = $clog2(DEPTH),
  parameter int RW = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wrreq,
  input  logic [DW-1:0]        d,
  input  logic [RW-1:0]        rdack,
  output logic [WINDOW*DW-1:0] q,
  output logic [WINDOW-1:0]    q_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic                 underflow
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [RW-1:0] ack_clamp;
  logic [AW:0]   ack_w, eff_ack;
  logic          wr_ok;
  always_comb begin
    ack_clamp = (rdack > RW'(WINDOW)) ? RW'(WINDOW) : rdack;
    ack_w = (AW+1)'(ack_clamp);
    eff_ack = (ack_w > count) ? count : ack_w;
    wr_ok = wrreq & ((count - eff_ack) < (AW+1)'(DEPTH));
  end
  assign empty = (count == '0);
  assign full = (count == (AW+1)'(DEPTH));
  assign almost_full = (count >= (AW+1)'(AF_LEVEL));
  genvar i;
  generate
    for (i = 0; i < WINDOW; i++) begin : g_win
      assign q[i*DW +: DW] = mem[rd_ptr + AW'(i)];
      assign q_valid[i] = (count > (AW+1)'(i));
    end
  endgenerate
  always_ff @(posedge clk)
    if (wr_ok && !reset && !flush) mem[wr_ptr] <= d;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count - eff_ack + {{AW{1'b0}}, wr_ok};
      rd_ptr <= rd_ptr + eff_ack[AW-1:0];
      wr_ptr <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
      overflow <= overflow | (wrreq & ~wr_ok);
      underflow <= underflow | (ack_w > count);
    end
  end
endmodule

// File: tb/tb_look_ahead_window_fifo.sv
// tb_look_ahead_window_fifo: scoreboard bench against a queue-based reference model.
module tb_look_ahead_window_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b0, flush = 1'b0, wrreq = 1'b0;
  logic [7:0]  d = '0;
  logic [2:0]  rdack = '0;
  logic [31:0] q;
  logic [3:0]  q_valid;
  logic        empty, full, almost_full, overflow, underflow;
  logic [3:0]  count;
  int tests = 0, fails = 0;
  typedef struct packed {
    logic [3:0]  cnt;
    logic [3:0]  qv;
    logic        emp, ful, af, ov, uf;
    logic [31:0] w;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] mq[$];
  bit m_ov = 0, m_uf = 0;
  always #5 clk = ~clk;
  look_ahead_window_fifo #(.DW(8), .DEPTH(8), .WINDOW(4), .AF_LEVEL(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wrreq(wrreq), .d(d), .rdack(rdack),
    .q(q), .q_valid(q_valid), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  task automatic step(input bit r, input bit f, input bit w, input logic [7:0] dd, input int a);
    int ea;
    exp_t x;
    @(negedge clk);
    reset = r; flush = f; wrreq = w; d = dd; rdack = 3'(a);
    if (r || f) begin
      mq.delete();
      m_ov = 0;
      m_uf = 0;
    end else begin
      if (a > 4) a = 4;
      ea = (a > mq.size()) ? mq.size() : a;
      if (a > mq.size()) m_uf = 1;
      repeat (ea) void'(mq.pop_front());
      if (w) begin
        if (mq.size() < 8) mq.push_back(dd);
        else m_ov = 1;
      end
    end
    x = '0;
    x.cnt = 4'(mq.size());
    for (int k = 0; k < 4; k++) begin
      x.qv[k] = (mq.size() > k);
      if (k < mq.size()) x.w[k*8 +: 8] = mq[k];
    end
    x.emp = (mq.size() == 0);
    x.ful = (mq.size() == 8);
    x.af = (mq.size() >= 6);
    x.ov = m_ov;
    x.uf = m_uf;
    sb.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if ({count, q_valid, empty, full, almost_full, overflow, underflow} !==
          {e.cnt, e.qv, e.emp, e.ful, e.af, e.ov, e.uf}) begin
        fails++;
        $display("FAIL status t=%0t: got cnt=%0d qv=%b e/f/af/ov/uf=%b%b%b%b%b want cnt=%0d qv=%b e/f/af/ov/uf=%b%b%b%b%b",
          $time, count, q_valid, empty, full, almost_full, overflow, underflow,
          e.cnt, e.qv, e.emp, e.ful, e.af, e.ov, e.uf);
      end
      for (int k = 0; k < 4; k++)
        if (k < e.cnt) begin
          tests++;
          if (q[k*8 +: 8] !== e.w[k*8 +: 8]) begin
            fails++;
            $display("FAIL slice%0d t=%0t: got %h want %h", k, $time, q[k*8 +: 8], e.w[k*8 +: 8]);
          end
        end
    end
  end
  initial begin
    step(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 8'(8'h10 + k), 0);
    step(0, 0, 0, 8'h00, 3);
    step(0, 0, 0, 8'h00, 2);
    for (int k = 0; k < 8; k++) step(0, 0, 1, 8'(8'h20 + k), 0);
    step(0, 0, 1, 8'h99, 0);
    step(0, 0, 1, 8'h98, 1);
    step(0, 0, 0, 8'h00, 4);
    step(0, 0, 0, 8'h00, 4);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 8'(8'hA0 + k), 0);
    step(0, 0, 0, 8'h00, 2);
    step(0, 0, 0, 8'h00, 4);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 8'(8'h30 + k), 0);
    step(0, 1, 1, 8'h77, 2);
    step(0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'(8'h40 + k), 0);
    step(0, 0, 1, 8'h55, 1);
    step(1, 1, 1, 8'h66, 2);
    step(0, 0, 0, 8'h00, 0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 4));
    step(0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/look_ahead_window_fifo.md
Name: look_ahead_window_fifo

Overview:
- Next-generation look-ahead FIFO: exposes a window of the WINDOW oldest entries at once, not only the head.
- The consumer retires 0..WINDOW entries per cycle via a variable rdack.
- Adds an occupancy count, a parametrised almost-full level, synchronous flush, and sticky overflow/underflow error flags.
- Sits between the DRAM/layer-io reader and the MXU operand staging, which consumes a variable number of words per cycle.

Parameters:
- DW, 16, data word width in bits.
- DEPTH, 16, entries; power of two, at least 4.
- WINDOW, 4, number of entries visible on q; at least 1 and at most DEPTH.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AW, $clog2(DEPTH), derived pointer width.
- RW, $clog2(WINDOW+1), derived rdack width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- wrreq  in  1  write d this cycle.
- d  in  DW  write data.
- rdack  in  RW  number of entries retired this cycle (0..WINDOW).
- q  out  WINDOW*DW  window data; slice i (bits i*DW +: DW) is the entry at rd_ptr+i mod DEPTH.
- q_valid  out  WINDOW  bit i = (count > i).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  AW+1  current occupancy.
- overflow  out  1  sticky; a write was dropped.
- underflow  out  1  sticky; rdack exceeded count.

Behaviour:
- Storage is a flop array of DEPTH x DW. Pointers wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
- Reset: count=0, wr_ptr=0, rd_ptr=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_full=0, q_valid=0. q is don't-care; storage is not cleared.
- All flags (empty, full, almost_full, q_valid) are combinational decodes of the registered count. No flag depends combinationally on wrreq or rdack.
- q is a combinational read of storage at rd_ptr+i. There is no read-request handshake: head data is present whenever q_valid[0]=1.
- A word written at cycle t appears in q (when within the window) and in count at t+1.
- rdack is sampled at the clock edge, with eff_ack = min(rdack, count):
  - rd_ptr += eff_ack.
  - If rdack > count, set underflow.
  - rdack > WINDOW is illegal and treated as WINDOW (clamped before the min).
- Write acceptance:
  - wr_ok = wrreq & (count - eff_ack < DEPTH), i.e. a same-cycle retire frees space (full bypass).
  - If wr_ok: mem[wr_ptr] = d and wr_ptr += 1.
  - If wrreq & !wr_ok: the word is dropped, overflow is set, and wr_ptr is unchanged.
- count_next = count - eff_ack + wr_ok. count never exceeds DEPTH and never goes below 0.
- Write on empty with rdack>0 in the same cycle: eff_ack=0. The written word is not retired that cycle.
- flush is synchronous and has priority over wrreq and rdack in the same cycle. It has the same effect as reset on count, pointers and the sticky flags.
- reset has priority over flush.
- reset asserted mid-operation: the state is discarded on the next edge and no partial update occurs.
- Sticky flags clear only on reset or flush.
- Wrap-around: window slices that straddle DEPTH-1 to 0 read mem[(rd_ptr+i) mod DEPTH].
- Latency: write-to-visible is 1 cycle; ack-to-window-shift is 1 cycle.
- There are no multicycle paths. The read mux is WINDOW instances of a DEPTH:1 mux.

Test Plan:
(DW=8, DEPTH=8, WINDOW=4, AF_LEVEL=6 for all scenarios)
- Basic fill and window: after reset, write 0x10..0x14 (5 cycles, rdack=0) -> count=5, q_valid=4'b1111, q slices = 0x10,0x11,0x12,0x13, empty=0, almost_full=0.
- Variable retire: from that state, rdack=3 for one cycle -> count=2, q slice0=0x13, slice1=0x14, q_valid=4'b0011. Then rdack=2 -> empty=1, underflow=0.
- Full, bypass and overflow:
  - Fill to 8 -> full=1, almost_full=1.
  - wrreq with rdack=0 -> word dropped, overflow=1, count=8.
  - wrreq with rdack=1 -> accepted, count stays 8, new word is the last entry.
- Wrap-around window: advance pointers so rd_ptr=6, then write 0xA0..0xA3 -> q slices = 0xA0..0xA3 read from mem[6],mem[7],mem[0],mem[1].
- Underflow clamp: count=2, rdack=4 -> count=0, rd_ptr advances by 2, underflow=1; underflow stays 1 after further idle cycles.
- Flush priority: count=5, flags set, same cycle flush=1, wrreq=1, rdack=2 -> next cycle count=0, empty=1, overflow=0, underflow=0, and the written word is absent. Repeat with reset=1 mid-fill -> identical cleared state.
